cosim_tohost_arbiter: RTL and testbench

- Shares one to-host cosim endpoint between NUM_CHANNELS independent valid/ready producers.
- Round-robin arbitration. Each accepted message is tagged with its channel index and staged in a one-entry output register.
- The output register drives the endpoint's DataInValid/DataInReady/DataIn.
- Sits between the per-channel ESI ports and a single to-host endpoint, so that only one DPI endpoint is registered per bundle.

---
 rtl/cosim_tohost_arbiter_pkg.sv | 20 ++
 rtl/cosim_tohost_arbiter_picker.sv | 41 ++++
 rtl/cosim_tohost_arbiter.sv | 102 ++++++++++
 tb/tb_cosim_tohost_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cosim_tohost_arbiter_pkg.sv
// Shared types and helper functions for the to-host cosim arbiter and its
// future from-host counterpart.
package cosim_arb_pkg;

    typedef logic [31:0] msg_count_t;

    function automatic int unsigned tag_bits(input int unsigned n);
        return $clog2(n);
    endfunction

    // Round-robin successor of a channel index, wrapping at n-1.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        if (ptr >= n - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cosim_tohost_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping to index 0.
module cosim_rr_picker
    import cosim_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned TW = tag_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [TW-1:0] idx,
    output logic          hit
);

    // Two passes: indices >= ptr first, then the wrapped-around low indices.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int j = 0; j < int'(N); j++) begin
            if (!hit && req[j] && (TW'(j) >= ptr)) begin
                hit      = 1'b1;
                idx      = TW'(j);
                grant[j] = 1'b1;
            end else begin
                hit = hit;
            end
        end
        for (int j = 0; j < int'(N); j++) begin
            if (!hit && req[j]) begin
                hit      = 1'b1;
                idx      = TW'(j);
                grant[j] = 1'b1;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/cosim_tohost_arbiter.sv
// Round-robin merge of NUM_CHANNELS valid/ready producers into one tagged
// to-host endpoint through a one-entry output register.
module cosim_tohost_arbiter
    import cosim_arb_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_BITS    = 32,
    localparam int unsigned TAG_BITS    = tag_bits(NUM_CHANNELS),
    localparam int unsigned OUT_BITS    = TAG_BITS + DATA_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CHANNELS-1:0]           InValid,
    output logic [NUM_CHANNELS-1:0]           InReady,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] InData,
    output logic                              DataOutValid,
    input  logic                              DataOutReady,
    output logic [OUT_BITS-1:0]               DataOut,
    output msg_count_t                        MsgCount
);

    logic [TAG_BITS-1:0]     ptr_r;
    logic                    out_valid_r;
    logic [OUT_BITS-1:0]     out_data_r;
    msg_count_t              msg_count_r;

    logic [NUM_CHANNELS-1:0] grant_s;
    logic [TAG_BITS-1:0]     idx_s;
    logic                    hit_s;
    logic                    space_s;
    logic                    accept_s;
    logic                    drain_s;
    logic [DATA_BITS-1:0]    payload_s;

    cosim_rr_picker #(
        .N  (NUM_CHANNELS),
        .TW (TAG_BITS)
    ) u_picker (
        .req   (InValid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (idx_s),
        .hit   (hit_s)
    );

    assign space_s  = !out_valid_r || DataOutReady;
    assign drain_s  = out_valid_r && DataOutReady;
    assign accept_s = hit_s && space_s && !rst;

    // Ready goes only to the granted channel, and never while reset is held.
    always_comb begin
        if (rst) begin
            InReady = '0;
        end else if (space_s) begin
            InReady = grant_s;
        end else begin
            InReady = '0;
        end
    end

    // Payload mux driven by the one-hot grant.
    always_comb begin
        payload_s = '0;
        for (int j = 0; j < int'(NUM_CHANNELS); j++) begin
            if (grant_s[j]) begin
                payload_s = InData[j*DATA_BITS +: DATA_BITS];
            end else begin
                payload_s = payload_s;
            end
        end
    end

    // Output stage: a refill on the same edge as a drain keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            msg_count_r <= 32'd0;
        end else begin
            if (accept_s) begin
                out_data_r  <= {idx_s, payload_s};
                out_valid_r <= 1'b1;
                ptr_r       <= TAG_BITS'(rr_next(32'(idx_s), NUM_CHANNELS));
            end else if (drain_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (drain_s) begin
                msg_count_r <= msg_count_r + 32'd1;
            end else begin
                msg_count_r <= msg_count_r;
            end
        end
    end

    assign DataOutValid = out_valid_r;
    assign DataOut      = out_data_r;
    assign MsgCount     = msg_count_r;

endmodule

// File: tb/tb_cosim_tohost_arbiter.sv
// Directed plus random stimulus for cosim_tohost_arbiter, checked against a
// transaction-level model of the arbitration rules.
module tb_cosim_tohost_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [33:0]  out_data;
    logic [31:0]  msg_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr    = 0;
    logic        m_valid  = 1'b0;
    logic [33:0] m_out    = 34'd0;
    logic [31:0] m_count  = 32'd0;

    cosim_tohost_arbiter #(
        .NUM_CHANNELS (4),
        .DATA_BITS    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .InValid      (in_valid),
        .InReady      (in_ready),
        .InData       (in_data),
        .DataOutValid (out_valid),
        .DataOutReady (out_ready),
        .DataOut      (out_data),
        .MsgCount     (msg_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input logic r, input logic [3:0] v, input logic [127:0] d, input logic rdy);
        int         g;
        logic       space;
        logic [3:0] exp_rdy;
        rst = r; in_valid = v; in_data = d; out_ready = rdy;
        #1;
        space = !m_valid || rdy;
        g = pick(m_ptr, v);
        exp_rdy = 4'b0000;
        if (g >= 0 && space && !r) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_out));
        check("msg_count", 64'(msg_count), 64'(m_count));
        if (r) begin
            m_valid = 1'b0; m_out = 34'd0; m_count = 32'd0; m_ptr = 0;
        end else begin
            if (m_valid && rdy) m_count = m_count + 32'd1;
            if (g >= 0 && space) begin
                m_out   = {g[1:0], d[g*32 +: 32]};
                m_valid = 1'b1;
                m_ptr   = (g + 1) % 4;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 4'b0000; in_data = 128'd0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step(1'b1, 4'b1111, rnd_data(), 1'b1);

        // All channels valid: grants 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            if (i >= 1) check("rr_tag", 64'(out_data[33:32]), 64'((i - 1) % 4));
            if (i == 5) check("rr_count", 64'(msg_count), 64'd4);
            step(1'b0, 4'b1111, rnd_data(), 1'b1);
        end

        // Only channels 1 and 3 valid, pointer now 2: tags 3,1,3.
        step(1'b0, 4'b1010, rnd_data(), 1'b1);
        check("skip_tag0", 64'(out_data[33:32]), 64'd3);
        step(1'b0, 4'b1010, rnd_data(), 1'b1);
        check("skip_tag1", 64'(out_data[33:32]), 64'd1);
        step(1'b0, 4'b1010, rnd_data(), 1'b1);
        check("skip_tag2", 64'(out_data[33:32]), 64'd3);

        // Backpressure with channel 2 payload staged.
        step(1'b0, 4'b0100, {32'd0, 32'hDEADBEEF, 64'd0}, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0100, {32'd0, 32'h12345678, 64'd0}, 1'b0);
            check("bp_data", 64'(out_data), 64'h2_DEADBEEF);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        step(1'b0, 4'b0100, {32'd0, 32'h12345678, 64'd0}, 1'b1);
        check("bp_release", 64'(out_data), 64'h2_12345678);

        // Single-requester burst without bubbles.
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 4'b0001, {96'd0, 32'(i)}, 1'b1);
            check("burst_data", 64'(out_data), 64'(i));
            check("burst_valid", 64'(out_valid), 64'd1);
        end
        step(1'b0, 4'b0000, rnd_data(), 1'b1);

        // Reset while a message is staged.
        step(1'b0, 4'b0100, rnd_data(), 1'b0);
        step(1'b1, 4'b1111, rnd_data(), 1'b1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(msg_count), 64'd0);
        step(1'b0, 4'b1111, rnd_data(), 1'b1);
        check("rst_ptr_tag", 64'(out_data[33:32]), 64'd0);

        // Counter wrap from a preloaded value.
        force dut.msg_count_r = 32'hFFFFFFFE;
        #1;
        release dut.msg_count_r;
        m_count = 32'hFFFFFFFE;
        step(1'b0, 4'b0000, rnd_data(), 1'b1);
        check("wrap_ff", 64'(msg_count), 64'hFFFFFFFF);
        step(1'b0, 4'b0001, rnd_data(), 1'b1);
        step(1'b0, 4'b0000, rnd_data(), 1'b1);
        check("wrap_zero", 64'(msg_count), 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'b0 || ($urandom_range(0, 59) == 0),
                 4'($urandom),
                 rnd_data(),
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
